// File: rtl/udp_recv.sv
// udp_recv: GMII receive-side UDP/IPv4 parser with MAC/IP/port filtering and payload streaming.
// Optional FCS checking is compiled in when UDP_RECV_CRC_EN is defined.
module udp_recv #(
  parameter int MIN_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_vl,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [15:0] i_port,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_sop,
  output logic        o_eop,
  output logic [47:0] o_src_mac,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic [15:0] o_len,
  output logic        o_pkt_done,
  output logic        o_pkt_ok,
  output logic [15:0] o_drop_cntr
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP
  } state_t;

  localparam logic [15:0] GAP_MIN = 16'(MIN_GAP);

  state_t      state;
  logic [10:0] idx;
  logic [2:0]  pre_cnt;
  logic [15:0] gap_cnt;
  logic        mac_self_ok, mac_bcast_ok, ip_ok, port_ok;
  logic [47:0] src_mac_q;
  logic [31:0] src_ip_q;
  logic [15:0] src_port_q, tot_len_q, udp_len_q, rem_q;
  logic [2:0]  tail_cnt;
  logic        first_q, hdr_pend;
  logic        crc_ok;

  logic [7:0]  mac_byte, ip_byte, port_byte;
  logic        mac_self_n, mac_bcast_n, ip_ok_n, port_ok_n;
  logic [15:0] cnt_inc;

  always_comb begin
    mac_byte = 8'h00;
    case (idx[2:0])
      3'd0:    mac_byte = i_self_mac[47:40];
      3'd1:    mac_byte = i_self_mac[39:32];
      3'd2:    mac_byte = i_self_mac[31:24];
      3'd3:    mac_byte = i_self_mac[23:16];
      3'd4:    mac_byte = i_self_mac[15:8];
      default: mac_byte = i_self_mac[7:0];
    endcase
    ip_byte = 8'h00;
    case (idx[1:0])
      2'd0:    ip_byte = i_self_ip[31:24];
      2'd1:    ip_byte = i_self_ip[23:16];
      2'd2:    ip_byte = i_self_ip[15:8];
      default: ip_byte = i_self_ip[7:0];
    endcase
    port_byte   = idx[0] ? i_port[7:0] : i_port[15:8];
    mac_self_n  = mac_self_ok & (i_data == mac_byte);
    mac_bcast_n = mac_bcast_ok & (i_data == 8'hFF);
    ip_ok_n     = ((idx == 11'd16) | ip_ok) & (i_data == ip_byte);
    port_ok_n   = ((idx == 11'd2) | port_ok) & (i_data == port_byte);
    cnt_inc     = (o_drop_cntr == 16'hFFFF) ? o_drop_cntr : o_drop_cntr + 16'd1;
  end

`ifdef UDP_RECV_CRC_EN
  logic [31:0] crc_q;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Register is re-seeded while hunting for the SFD, so the first ETH_HDR byte starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (state == IDLE || state == PREAMBLE) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (i_data_vl && state != DROP) begin
      crc_q <= crc_next(crc_q, i_data);
    end
  end

  assign crc_ok = (crc_q == 32'hDEBB20E3);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      pre_cnt      <= '0;
      gap_cnt      <= '0;
      mac_self_ok  <= 1'b0;
      mac_bcast_ok <= 1'b0;
      ip_ok        <= 1'b0;
      port_ok      <= 1'b0;
      src_mac_q    <= '0;
      src_ip_q     <= '0;
      src_port_q   <= '0;
      tot_len_q    <= '0;
      udp_len_q    <= '0;
      rem_q        <= '0;
      tail_cnt     <= '0;
      first_q      <= 1'b0;
      hdr_pend     <= 1'b0;
      o_data       <= '0;
      o_data_vl    <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_src_mac    <= '0;
      o_src_ip     <= '0;
      o_src_port   <= '0;
      o_len        <= '0;
      o_pkt_done   <= 1'b0;
      o_pkt_ok     <= 1'b0;
      o_drop_cntr  <= '0;
    end else begin
      o_data_vl  <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_ok   <= 1'b0;
      hdr_pend   <= 1'b0;

      if (i_data_vl) gap_cnt <= '0;
      else if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;

      // Sender info is published one edge after the UDP header, aligned with the first payload beat.
      if (hdr_pend) begin
        o_src_mac  <= src_mac_q;
        o_src_ip   <= src_ip_q;
        o_src_port <= src_port_q;
        o_len      <= udp_len_q - 16'd8;
      end

      case (state)
        IDLE: begin
          if (i_data_vl) begin
            if (gap_cnt >= GAP_MIN) begin
              if (i_data == 8'h55) begin
                pre_cnt <= 3'd1;
                state   <= PREAMBLE;
              end else if (i_data == 8'hD5) begin
                idx          <= '0;
                mac_self_ok  <= 1'b1;
                mac_bcast_ok <= 1'b1;
                state        <= ETH_HDR;
              end else begin
                state <= DROP;
              end
            end else begin
              state <= DROP;
            end
          end
        end

        PREAMBLE: begin
          if (!i_data_vl) begin
            state <= IDLE;
          end else if (i_data == 8'h55) begin
            if (pre_cnt == 3'd7) state <= DROP;
            else pre_cnt <= pre_cnt + 3'd1;
          end else if (i_data == 8'hD5) begin
            idx          <= '0;
            mac_self_ok  <= 1'b1;
            mac_bcast_ok <= 1'b1;
            state        <= ETH_HDR;
          end else begin
            state <= DROP;
          end
        end

        ETH_HDR: begin
          if (i_data_vl) begin
            idx <= idx + 11'd1;
            if (idx < 11'd6) begin
              mac_self_ok  <= mac_self_n;
              mac_bcast_ok <= mac_bcast_n;
              if (idx == 11'd5 && !(mac_self_n || mac_bcast_n)) state <= DROP;
            end else if (idx < 11'd12) begin
              src_mac_q <= {src_mac_q[39:0], i_data};
            end else if (idx == 11'd12) begin
              if (i_data != 8'h08) state <= DROP;
            end else begin
              if (i_data != 8'h00) begin
                state <= DROP;
              end else begin
                idx   <= '0;
                state <= IP_HDR;
              end
            end
          end else if (idx >= 11'd6) begin
            o_pkt_done  <= 1'b1;
            o_drop_cntr <= cnt_inc;
            state       <= IDLE;
          end else begin
            state <= IDLE;
          end
        end

        IP_HDR: begin
          if (i_data_vl) begin
            idx <= idx + 11'd1;
            if (idx == 11'd0 && i_data != 8'h45) state <= DROP;
            if (idx == 11'd2) tot_len_q[15:8] <= i_data;
            if (idx == 11'd3) tot_len_q[7:0] <= i_data;
            if (idx == 11'd9 && i_data != 8'h11) state <= DROP;
            if (idx >= 11'd12 && idx <= 11'd15) src_ip_q <= {src_ip_q[23:0], i_data};
            if (idx >= 11'd16) ip_ok <= ip_ok_n;
            if (idx == 11'd19) begin
              idx   <= '0;
              state <= ip_ok_n ? UDP_HDR : DROP;
            end
          end else begin
            o_pkt_done  <= 1'b1;
            o_drop_cntr <= cnt_inc;
            state       <= IDLE;
          end
        end

        UDP_HDR: begin
          if (i_data_vl) begin
            idx <= idx + 11'd1;
            if (idx <= 11'd1) src_port_q <= {src_port_q[7:0], i_data};
            if (idx == 11'd2 || idx == 11'd3) port_ok <= port_ok_n;
            if (idx == 11'd3 && !port_ok_n) state <= DROP;
            if (idx == 11'd4 || idx == 11'd5) udp_len_q <= {udp_len_q[7:0], i_data};
            if (idx == 11'd7) begin
              // Widened compare so a short IP total length cannot wrap the bound.
              if (udp_len_q < 16'd8 || ({1'b0, udp_len_q} + 17'd20) > {1'b0, tot_len_q}) begin
                o_drop_cntr <= cnt_inc;
                state       <= DROP;
              end else begin
                hdr_pend <= 1'b1;
                rem_q    <= udp_len_q - 16'd8;
                first_q  <= 1'b1;
                tail_cnt <= '0;
                state    <= (udp_len_q == 16'd8) ? TAIL : PAYLOAD;
              end
            end
          end else begin
            o_pkt_done  <= 1'b1;
            o_drop_cntr <= cnt_inc;
            state       <= IDLE;
          end
        end

        PAYLOAD: begin
          if (i_data_vl) begin
            o_data    <= i_data;
            o_data_vl <= 1'b1;
            o_sop     <= first_q;
            o_eop     <= (rem_q == 16'd1);
            first_q   <= 1'b0;
            rem_q     <= rem_q - 16'd1;
            if (rem_q == 16'd1) state <= TAIL;
          end else begin
            o_pkt_done  <= 1'b1;
            o_drop_cntr <= cnt_inc;
            state       <= IDLE;
          end
        end

        TAIL: begin
          if (i_data_vl) begin
            if (tail_cnt != 3'd7) tail_cnt <= tail_cnt + 3'd1;
          end else begin
            o_pkt_done <= 1'b1;
            o_pkt_ok   <= (tail_cnt >= 3'd4) && crc_ok;
            if (!((tail_cnt >= 3'd4) && crc_ok)) o_drop_cntr <= cnt_inc;
            state <= IDLE;
          end
        end

        default: begin
          if (!i_data_vl) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_recv.sv
// tb_udp_recv: randomized frame-level bench for udp_recv with a field-level acceptance model.
module tb_udp_recv;

  localparam logic [47:0] SELF_MAC  = 48'h0023_543C_471B;
  localparam logic [31:0] SELF_IP   = 32'h0A00_0021;
  localparam logic [15:0] SELF_PORT = 16'd50000;
`ifdef UDP_RECV_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_data_vl = 1'b0;
  logic [7:0]  o_data;
  logic        o_data_vl, o_sop, o_eop, o_pkt_done, o_pkt_ok;
  logic [47:0] o_src_mac;
  logic [31:0] o_src_ip;
  logic [15:0] o_src_port, o_len, o_drop_cntr;

  udp_recv #(.MIN_GAP(1)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_vl(i_data_vl),
    .i_self_mac(SELF_MAC), .i_self_ip(SELF_IP), .i_port(SELF_PORT),
    .o_data(o_data), .o_data_vl(o_data_vl), .o_sop(o_sop), .o_eop(o_eop),
    .o_src_mac(o_src_mac), .o_src_ip(o_src_ip), .o_src_port(o_src_port),
    .o_len(o_len), .o_pkt_done(o_pkt_done), .o_pkt_ok(o_pkt_ok),
    .o_drop_cntr(o_drop_cntr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  frm[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  int          pl_off;
  int          sop_pos[$];
  int          eop_pos[$];
  int          done_n;
  logic        ok_last;
  logic [15:0] len_at_sop;

  logic [47:0] m_mac;
  logic [31:0] m_ip;
  logic [15:0] m_port, m_len, m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (o_data_vl) begin
      obs_q.push_back(o_data);
      if (o_sop) sop_pos.push_back(obs_q.size());
      if (o_eop) eop_pos.push_back(obs_q.size());
      if (obs_q.size() == 1) len_at_sop = o_len;
    end
    if (o_pkt_done) begin
      done_n++;
      ok_last = o_pkt_ok;
    end
  end

  // ---------------- frame construction ----------------
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_n(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic build_frame(input logic [47:0] dmac, input logic [47:0] smac,
                             input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] sport, input logic [15:0] dport,
                             input int plen, input bit flip);
    logic [31:0] crc;
    logic [15:0] ulen;
    frm.delete();
    exp_q.delete();
    ulen = 16'(plen + 8);
    for (int i = 0; i < 7; i++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    push_n({16'h0, dmac}, 6);
    push_n({16'h0, smac}, 6);
    push_n(64'h0800, 2);
    push_n(64'h4500, 2);
    push_n({48'h0, ulen + 16'd20}, 2);
    push_n(64'h0000_4000_4011_0000, 8);
    push_n({32'h0, sip}, 4);
    push_n({32'h0, dip}, 4);
    push_n({48'h0, sport}, 2);
    push_n({48'h0, dport}, 2);
    push_n({48'h0, ulen}, 2);
    push_n(64'h0, 2);
    pl_off = frm.size();
    for (int i = 0; i < plen; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      frm.push_back(exp_q[i]);
    end
    while (frm.size() - 8 < 60) frm.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < frm.size(); i++) crc = crc_byte(crc, frm[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
    if (flip) frm[frm.size() - 2] = frm[frm.size() - 2] ^ 8'h10;
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input int cut_at, input int rst_at);
    obs_q.delete();
    sop_pos.delete();
    eop_pos.delete();
    done_n = 0;
    ok_last = 1'b0;
    len_at_sop = '0;
    for (int i = 0; i < frm.size(); i++) begin
      if (cut_at >= 0 && i == pl_off + cut_at) break;
      i_data    = frm[i];
      i_data_vl = 1'b1;
      if (rst_at >= 0 && i == pl_off + rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_data_vl", o_data_vl, 0);
        check("rst_len", o_len, 0);
        check("rst_src_ip", o_src_ip, 0);
        check("rst_cntr", o_drop_cntr, 0);
        check("rst_done", o_pkt_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    i_data_vl = 1'b0;
    i_data    = '0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // ---------------- model + per-frame comparison ----------------
  task automatic run_case(input string tag, input logic [47:0] dmac, input logic [31:0] dip,
                          input logic [15:0] dport, input int plen, input int cut_at,
                          input bit flip, input int rst_at);
    logic [47:0] smac;
    logic [31:0] sip;
    logic [15:0] sport;
    bit accept, exp_ok;
    int exp_beats, n_cmp;
    smac  = {16'h0200, 32'($urandom)};
    sip   = {8'h0A, 24'($urandom)};
    sport = 16'($urandom_range(1024, 65535));
    if (tag == "good64") begin
      sip = 32'h0A00_0002;
      sport = 16'd50016;
    end
    build_frame(dmac, smac, sip, dip, sport, dport, plen, flip);
    send_frame(cut_at, rst_at);

    accept = (dmac == SELF_MAC || dmac == 48'hFFFF_FFFF_FFFF) && dip == SELF_IP &&
             dport == SELF_PORT;
    if (rst_at >= 0) begin
      m_mac = '0; m_ip = '0; m_port = '0; m_len = '0; m_cnt = '0;
      check({tag, "_done"}, done_n, 0);
      n_cmp = (obs_q.size() < rst_at) ? obs_q.size() : rst_at;
      check({tag, "_beats_le"}, obs_q.size() <= rst_at, 1);
    end else begin
      exp_beats = !accept ? 0 : (cut_at >= 0 ? cut_at : plen);
      exp_ok    = accept && cut_at < 0 && !(CRC_EN && flip);
      if (accept) begin
        m_mac = smac; m_ip = sip; m_port = sport; m_len = 16'(plen);
        if (!exp_ok && m_cnt != 16'hFFFF) m_cnt++;
      end
      check({tag, "_beats"}, obs_q.size(), exp_beats);
      check({tag, "_done"}, done_n, accept ? 1 : 0);
      if (accept) check({tag, "_ok"}, ok_last, exp_ok);
      if (exp_beats > 0) begin
        check({tag, "_sop_n"}, sop_pos.size(), 1);
        if (sop_pos.size() > 0) check({tag, "_sop_pos"}, sop_pos[0], 1);
        check({tag, "_len_at_sop"}, len_at_sop, plen);
      end
      check({tag, "_eop_n"}, eop_pos.size(), (exp_beats > 0 && cut_at < 0) ? 1 : 0);
      if (eop_pos.size() > 0 && cut_at < 0) check({tag, "_eop_pos"}, eop_pos[0], exp_beats);
      n_cmp = (obs_q.size() < exp_beats) ? obs_q.size() : exp_beats;
    end
    for (int i = 0; i < n_cmp; i++) check({tag, "_data"}, obs_q[i], exp_q[i]);
    check({tag, "_len"}, o_len, m_len);
    check({tag, "_src_ip"}, o_src_ip, m_ip);
    check({tag, "_src_port"}, o_src_port, m_port);
    check({tag, "_src_mac"}, o_src_mac, m_mac);
    check({tag, "_cntr"}, o_drop_cntr, m_cnt);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int kind, plen, cut;
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [15:0] dport;
    m_mac = '0; m_ip = '0; m_port = '0; m_len = '0; m_cnt = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_vl", o_data_vl, 0);
    check("reset_sop_eop", {o_sop, o_eop}, 0);
    check("reset_done_ok", {o_pkt_done, o_pkt_ok}, 0);
    check("reset_cntr", o_drop_cntr, 0);
    check("reset_hdr", {o_len, o_src_port, o_src_ip}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run_case("good64",   SELF_MAC, SELF_IP, SELF_PORT, 64, -1, 1'b0, -1);
    run_case("badport",  SELF_MAC, SELF_IP, 16'd50001, 64, -1, 1'b0, -1);
    run_case("badmac",   48'h0023_543C_471C, SELF_IP, SELF_PORT, 64, -1, 1'b0, -1);
    run_case("len8",     SELF_MAC, SELF_IP, SELF_PORT, 0, -1, 1'b0, -1);
    run_case("cut10",    SELF_MAC, SELF_IP, SELF_PORT, 64, 10, 1'b0, -1);
    run_case("fcsflip",  SELF_MAC, SELF_IP, SELF_PORT, 64, -1, 1'b1, -1);
    run_case("onebyte",  SELF_MAC, SELF_IP, SELF_PORT, 1, -1, 1'b0, -1);
    run_case("rstmid",   SELF_MAC, SELF_IP, SELF_PORT, 64, -1, 1'b0, 5);
    run_case("afterrst", SELF_MAC, SELF_IP, SELF_PORT, 64, -1, 1'b0, -1);

    for (int n = 0; n < 12; n++) begin
      kind  = $urandom_range(0, 5);
      plen  = $urandom_range(0, 60);
      dmac  = (kind == 2) ? {SELF_MAC[47:8], 8'($urandom_range(0, 254)) ^ 8'h1A}
            : (kind == 3) ? 48'hFFFF_FFFF_FFFF : SELF_MAC;
      dip   = (kind == 4) ? SELF_IP ^ 32'h0000_0100 : SELF_IP;
      dport = (kind == 1) ? SELF_PORT + 16'($urandom_range(1, 100)) : SELF_PORT;
      cut   = (kind == 5 && plen > 0) ? $urandom_range(0, plen - 1) : -1;
      run_case("rand", dmac, dip, dport, plen, cut, ($urandom_range(0, 3) == 0), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/udp_recv.md
# udp_recv

Receive-side UDP/IPv4 frame parser: the receive counterpart of `udp_send`. It sits on the GMII receive byte stream (`eth_rx_clk` domain) alongside `eth_recv`. It filters frames addressed to this node's MAC, IP and UDP port, and captures sender addressing. It streams the UDP payload out with start/end markers and reports per-frame status.

## Interface
Parameters:
- `MIN_GAP`, default 1: idle cycles of `i_data_vl` low required before a new frame is accepted.

Ports:
- `clk`  in  1  receive byte clock (`eth_rx_clk`).
- `rst`  in  1  reset, asynchronous, active-high.
- `i_data`  in  8  GMII receive byte.
- `i_data_vl`  in  1  receive data valid; high for preamble through FCS.
- `i_self_mac`  in  48  own MAC address.
- `i_self_ip`  in  32  own IPv4 address.
- `i_port`  in  16  UDP destination port to accept.
- `o_data`  out  8  payload byte.
- `o_data_vl`  out  1  payload byte valid.
- `o_sop`  out  1  first payload byte marker.
- `o_eop`  out  1  last payload byte marker.
- `o_src_mac`  out  48  sender MAC of the last accepted frame.
- `o_src_ip`  out  32  sender IP.
- `o_src_port`  out  16  sender UDP port.
- `o_len`  out  16  payload length in bytes (UDP length − 8).
- `o_pkt_done`  out  1  one-cycle end-of-frame pulse for accepted frames.
- `o_pkt_ok`  out  1  status qualifying `o_pkt_done`.
- `o_drop_cntr`  out  16  errored-frame counter, saturating.

## Operation
- States: IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP.
- Byte index counter is 11 bits; it resets on entry to each header state.
- IDLE → PREAMBLE on `i_data_vl` rising, after ≥ `MIN_GAP` low cycles.
- PREAMBLE: accepts 0x55 bytes and goes to ETH_HDR on 0xD5. More than 7 0x55 bytes, or any other byte, → DROP.
- ETH_HDR (14 bytes):
  - dst MAC must equal `i_self_mac` or FF:FF:FF:FF:FF:FF.
  - src MAC is captured.
  - EtherType must be 0x0800.
- IP_HDR (20 bytes):
  - byte 0 must be 0x45.
  - total length is captured.
  - protocol (byte 9) must be 0x11.
  - src IP (bytes 12–15) is captured.
  - dst IP (bytes 16–19) must equal `i_self_ip`.
  - IP header checksum is not verified.
- UDP_HDR (8 bytes):
  - src port is captured.
  - dst port must equal `i_port`.
  - UDP length L is captured; checksum is ignored.
  - Malformed if L < 8 or L > IP total length − 20.
- Any filter mismatch → DROP silently: no done pulse, no counter change.
- At end of UDP_HDR, the `o_src_*` and `o_len` = L − 8 outputs update together and hold until the next accepted UDP header.
- PAYLOAD: emits L − 8 bytes, then → TAIL. If L == 8, skip directly to TAIL with no data beats.
- TAIL: consumes padding and FCS until `i_data_vl` falls.
- On `i_data_vl` falling in TAIL, pulse `o_pkt_done`. `o_pkt_ok` = 1 only if ≥ 4 bytes were seen in TAIL and the CRC passed (see Configuration).
- `i_data_vl` falling in ETH_HDR after the filter has passed, or in IP_HDR, UDP_HDR or PAYLOAD → truncation:
  - `o_pkt_done` pulses with `o_pkt_ok` = 0.
  - `o_eop` is never asserted.
- Malformed length → DROP, counted as an error.
- Every `o_pkt_done` with `o_pkt_ok` = 0 increments `o_drop_cntr`, saturating at 0xFFFF.
- DROP → IDLE once `i_data_vl` is low.

## Timing
- All outputs are registered and reset to 0; state resets to IDLE.
- Payload latency: `o_data`/`o_data_vl` follow the input byte by 1 clk.
- `o_sop` and `o_eop` are coincident with `o_data_vl` on the first and last bytes. With a 1-byte payload, both are asserted on the same beat.
- `o_pkt_done` asserts 1 clk after the first cycle with `i_data_vl` low.
- Header outputs update on the same edge as the first payload beat, or 1 clk after the last UDP header byte if L == 8.
- No back-pressure: the consumer must accept one byte per clk.
- `rst` asserted mid-frame clears everything immediately. If `i_data_vl` is still high after release, the FSM sits in DROP until it falls; that partial frame is neither reported nor counted.

## Configuration
- `UDP_RECV_CRC_EN` defined:
  - Running CRC-32 over dst MAC through FCS: reflected, poly 0xEDB88320, init 0xFFFFFFFF.
  - Frame passes if the final register equals 0xDEBB20E3.
  - CRC failure gives `o_pkt_ok` = 0 and increments `o_drop_cntr`.
- Undefined: no CRC logic; `o_pkt_ok` depends only on the length/truncation checks.

## Test plan
Common setup: self MAC 00:23:54:3C:47:1B, IP 10.0.0.33, port 50000.
- Valid 64-byte UDP payload from 10.0.0.2:50016:
  - 64 beats, `o_sop` on beat 1, `o_eop` on beat 64.
  - `o_len` = 64, `o_src_ip` = 0x0A000002, `o_src_port` = 50016.
  - `o_pkt_done` = 1 with `o_pkt_ok` = 1; counter stays 0.
- Same frame with dst port 50001, then with wrong dst MAC:
  - no payload beats, no `o_pkt_done`, counter stays 0.
- UDP length 8, padded to a minimum frame:
  - no payload beats; `o_len` = 0; `o_pkt_done`/`o_pkt_ok` = 1.
- `i_data_vl` dropped after payload byte 10 of 64:
  - 10 beats, no `o_eop`; `o_pkt_done` with `o_pkt_ok` = 0; counter = 1.
- With `UDP_RECV_CRC_EN`, one FCS bit flipped:
  - full payload streamed; `o_pkt_ok` = 0; counter increments.
  - Without the macro: `o_pkt_ok` = 1.
- `rst` pulsed at payload byte 5:
  - outputs go to 0 immediately; remainder of the frame is ignored.
  - Next valid frame is received correctly.
